// File: rtl/cpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Tick-paced multi-cycle control FSM: PC, IR load and gated write.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int LAST_ADDR = 255,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic                 halt_req,
    input  logic [31:0]          instr,
    input  logic                 regWrite_in,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 ir_load,
    output logic                 reg_we,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PAUSE     = 3'd5,
        S_HALT      = 3'd6,
        S_BAD       = 3'd7
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_LAST_PC = PC_WIDTH'(LAST_ADDR);

    state_t                 state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   start_pend_q;
    logic                   step_pend_q;

    logic w_halt_instr;
    logic w_at_last;
    logic w_start_window;

    assign w_halt_instr   = (instr == 32'h0) || (instr[6:0] == 7'h73);
    assign w_at_last      = (pc_q == c_LAST_PC);
    assign w_start_window = (state_q == S_IDLE) || (state_q == S_HALT);

    // Later non-blocking writes in the tick case override the request capture,
    // so a flag consumed on this edge always ends up cleared.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            retired_q    <= '0;
            start_pend_q <= 1'b0;
            step_pend_q  <= 1'b0;
        end else begin
            if (start && w_start_window) begin
                start_pend_q <= 1'b1;
            end
            if (step && (state_q == S_PAUSE)) begin
                step_pend_q <= 1'b1;
            end

            if (state_q == S_BAD) begin
                state_q <= S_HALT;
            end else if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (start_pend_q) begin
                            state_q      <= S_FETCH;
                            start_pend_q <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        state_q <= halt_req ? S_HALT : S_DECODE;
                    end
                    S_DECODE: begin
                        state_q <= (halt_req || w_halt_instr) ? S_HALT : S_EXECUTE;
                    end
                    S_EXECUTE: begin
                        state_q <= halt_req ? S_HALT : S_WRITEBACK;
                    end
                    S_WRITEBACK: begin
                        if (~&retired_q) begin
                            retired_q <= retired_q + CNT_WIDTH'(1);
                        end
                        if (w_at_last) begin
                            state_q <= S_HALT;
                        end else begin
                            pc_q <= pc_q + PC_WIDTH'(1);
                            if (halt_req) begin
                                state_q <= S_HALT;
                            end else if (step_mode) begin
                                state_q <= S_PAUSE;
                            end else begin
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (halt_req) begin
                            state_q     <= S_HALT;
                            step_pend_q <= 1'b0;
                        end else if (step_pend_q || !step_mode) begin
                            state_q     <= S_FETCH;
                            step_pend_q <= 1'b0;
                        end
                    end
                    S_HALT: begin
                        // A restart takes priority over any concurrent halt_req.
                        if (start_pend_q) begin
                            pc_q         <= '0;
                            retired_q    <= '0;
                            state_q      <= S_FETCH;
                            start_pend_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_HALT;
                    end
                endcase
            end
        end
    end

    // Strobes are qualified by reset so an abandoned instruction never writes.
    assign ir_load = reset & tick & (state_q == S_FETCH);
    assign reg_we  = reset & tick & regWrite_in & (state_q == S_WRITEBACK);
    assign halted  = (state_q == S_HALT);
    assign pc      = pc_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Randomised and directed checking of two cpu_sequencer builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic start = 1'b0;
    logic step_mode = 1'b0;
    logic step = 1'b0;
    logic halt_req = 1'b0;
    logic regWrite_in = 1'b0;

    logic [31:0] mem [256];
    logic [31:0] instr0, instr1;
    logic [7:0]  pc0, pc1;
    logic        ir0, ir1, we0, we1, hl0, hl1;
    logic [2:0]  st0, st1;
    logic [15:0] rt0, rt1;

    assign instr0 = mem[pc0];
    assign instr1 = mem[pc1];

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_WIDTH(8), .LAST_ADDR(255), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .step_mode(step_mode),
        .step(step), .halt_req(halt_req), .instr(instr0), .regWrite_in(regWrite_in),
        .pc(pc0), .ir_load(ir0), .reg_we(we0), .state(st0), .halted(hl0), .retired(rt0)
    );

    cpu_sequencer #(.PC_WIDTH(8), .LAST_ADDR(3), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .step_mode(step_mode),
        .step(step), .halt_req(halt_req), .instr(instr1), .regWrite_in(regWrite_in),
        .pc(pc1), .ir_load(ir1), .reg_we(we1), .state(st1), .halted(hl1), .retired(rt1)
    );

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (instruction-level view) ----------------
    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_HALT  = 3;

    int m_mode [2];
    int m_stg  [2];   // 0 fetch, 1 decode, 2 execute, 3 writeback
    int m_pc   [2];
    int m_ret  [2];
    bit m_sp   [2];
    bit m_tp   [2];
    int last   [2] = '{255, 3};
    bit model_on = 1'b0;

    function automatic bit is_halt_instr(input logic [31:0] w);
        return (w == 32'h0) || (w[6:0] == 7'h73);
    endfunction

    function automatic int exp_state(input int k);
        case (m_mode[k])
            MD_IDLE:  return 0;
            MD_RUN:   return 1 + m_stg[k];
            MD_PAUSE: return 5;
            default:  return 6;
        endcase
    endfunction

    task automatic model_step(input int k);
        int md;
        bit take_s, leave_p;
        md = m_mode[k];
        take_s = 1'b0;
        leave_p = 1'b0;
        if (!reset) begin
            m_mode[k] = MD_IDLE; m_stg[k] = 0; m_pc[k] = 0; m_ret[k] = 0;
            m_sp[k] = 1'b0; m_tp[k] = 1'b0;
            return;
        end
        if (tick) begin
            if (md == MD_IDLE || md == MD_HALT) begin
                if (m_sp[k]) begin
                    take_s = 1'b1;
                    if (md == MD_HALT) begin m_pc[k] = 0; m_ret[k] = 0; end
                    m_mode[k] = MD_RUN; m_stg[k] = 0;
                end
            end else if (md == MD_PAUSE) begin
                if (halt_req) begin
                    leave_p = 1'b1; m_mode[k] = MD_HALT;
                end else if (m_tp[k] || !step_mode) begin
                    leave_p = 1'b1; m_mode[k] = MD_RUN; m_stg[k] = 0;
                end
            end else if (m_stg[k] == 3) begin
                if (m_ret[k] < 65535) m_ret[k]++;
                if (m_pc[k] == last[k]) m_mode[k] = MD_HALT;
                else begin
                    m_pc[k] = m_pc[k] + 1;
                    if (halt_req)       m_mode[k] = MD_HALT;
                    else if (step_mode) m_mode[k] = MD_PAUSE;
                    else                m_stg[k] = 0;
                end
            end else if (halt_req || (m_stg[k] == 1 && is_halt_instr(mem[m_pc[k]]))) begin
                m_mode[k] = MD_HALT;
            end else begin
                m_stg[k]++;
            end
        end
        if (take_s) m_sp[k] = 1'b0;
        else if (start && (md == MD_IDLE || md == MD_HALT)) m_sp[k] = 1'b1;
        if (leave_p) m_tp[k] = 1'b0;
        else if (step && md == MD_PAUSE) m_tp[k] = 1'b1;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        model_on = 1'b1;
    end

    task automatic cmp_inst(input int k, input logic [2:0] st, input logic [7:0] pc,
                            input logic ir, input logic we, input logic hl, input logic [15:0] rt);
        bit running;
        running = (m_mode[k] == MD_RUN);
        chk($sformatf("u%0d.state", k), 32'(st), 32'(exp_state(k)));
        chk($sformatf("u%0d.pc", k), 32'(pc), 32'(m_pc[k]));
        chk($sformatf("u%0d.retired", k), 32'(rt), 32'(m_ret[k]));
        chk($sformatf("u%0d.halted", k), 32'(hl), 32'(m_mode[k] == MD_HALT));
        chk($sformatf("u%0d.ir_load", k), 32'(ir), 32'(reset && tick && running && m_stg[k] == 0));
        chk($sformatf("u%0d.reg_we", k), 32'(we),
            32'(reset && tick && regWrite_in && running && m_stg[k] == 3));
    endtask

    int we_cnt0 = 0, we_cnt1 = 0, ir_cnt0 = 0;

    always @(negedge clk) begin
        if (model_on) begin
            cmp_inst(0, st0, pc0, ir0, we0, hl0, rt0);
            cmp_inst(1, st1, pc1, ir1, we1, hl1, rt1);
        end
        if (we0 === 1'b1) we_cnt0++;
        if (we1 === 1'b1) we_cnt1++;
        if (ir0 === 1'b1) ir_cnt0++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clk_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; clk_n(1);
            tick = 1'b0; clk_n(3);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; clk_n(1); start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; clk_n(2); reset = 1'b1; clk_n(1);
    endtask

    task automatic fill_random_mem();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            if ($urandom_range(0, 11) == 0) w = ($urandom_range(0, 1) == 0) ? 32'h0 : {w[31:7], 7'h73};
            mem[i] = w;
        end
    endtask

    int base;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h00500093;
        regWrite_in = 1'b1;
        clk_n(1);
        do_reset();
        chk("rst_state", 32'(st0), 0);
        chk("rst_pc", 32'(pc0), 0);

        // Free run: 9 ticks = start + two full instructions.
        pulse_start();
        ticks(9);
        chk("run_pc", 32'(pc0), 2);
        chk("run_ret", 32'(rt0), 2);
        chk("run_state", 32'(st0), 1);
        chk("run_ir_cnt", 32'(ir_cnt0), 2);
        chk("run_we_cnt", 32'(we_cnt0), 2);

        // Single-step mode.
        step_mode = 1'b1;
        ticks(4);
        chk("pause_state", 32'(st0), 5);
        chk("pause_pc", 32'(pc0), 3);
        ticks(20);
        chk("pause_hold_state", 32'(st0), 5);
        chk("pause_hold_ret", 32'(rt0), 3);
        chk("pause_hold_we", 32'(we_cnt0), 3);
        step = 1'b1; clk_n(1); step = 1'b0;
        ticks(5);
        chk("step_we", 32'(we_cnt0), 4);
        chk("step_pc", 32'(pc0), 4);
        chk("step_state", 32'(st0), 5);
        chk("last_halted", 32'(hl1), 1);
        chk("last_pc", 32'(pc1), 3);
        chk("last_ret", 32'(rt1), 4);

        // Halt-on-instruction at pc=3.
        step_mode = 1'b0;
        do_reset();
        mem[3] = 32'h00000073;
        base = we_cnt0;
        pulse_start();
        ticks(18);
        chk("hi_halted", 32'(hl0), 1);
        chk("hi_pc", 32'(pc0), 3);
        chk("hi_ret", 32'(rt0), 3);
        chk("hi_we", 32'(we_cnt0 - base), 3);
        pulse_start();
        ticks(1);
        chk("restart_state", 32'(st0), 1);
        chk("restart_pc", 32'(pc0), 0);
        chk("restart_ret", 32'(rt0), 0);
        mem[3] = 32'h00500093;

        // halt_req in EXECUTE, then in WRITEBACK.
        ticks(2);
        base = we_cnt0;
        halt_req = 1'b1; ticks(1); halt_req = 1'b0;
        chk("hx_state", 32'(st0), 6);
        chk("hx_pc", 32'(pc0), 0);
        chk("hx_we", 32'(we_cnt0 - base), 0);
        pulse_start();
        ticks(4);
        halt_req = 1'b1; ticks(1); halt_req = 1'b0;
        chk("hw_state", 32'(st0), 6);
        chk("hw_pc", 32'(pc0), 1);
        chk("hw_we", 32'(we_cnt0 - base), 1);

        // Reset on the writeback tick abandons the write.
        pulse_start();
        ticks(4);
        base = we_cnt0;
        reset = 1'b0; tick = 1'b1; clk_n(1);
        reset = 1'b1; tick = 1'b0; clk_n(1);
        chk("mr_state", 32'(st0), 0);
        chk("mr_pc", 32'(pc0), 0);
        chk("mr_we", 32'(we_cnt0 - base), 0);
        pulse_start();
        ticks(1);
        pulse_start();
        do_reset();
        ticks(3);
        chk("ign_state", 32'(st0), 0);

        // Randomised run against the model.
        for (int r = 0; r < 3; r++) begin
            fill_random_mem();
            do_reset();
            for (int c = 0; c < 5000; c++) begin
                tick        = ($urandom_range(0, 2) == 0);
                start       = ($urandom_range(0, 19) == 0);
                step        = ($urandom_range(0, 7) == 0);
                halt_req    = ($urandom_range(0, 59) == 0);
                regWrite_in = $urandom_range(0, 1);
                if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
                reset       = ($urandom_range(0, 399) != 0);
                clk_n(1);
            end
        end
        reset = 1'b1; tick = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        clk_n(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
